// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write arbiter and
//               the round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

   // Arbiter FSM state encoding
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Default producer count and the matching owner-id width
   localparam int DEF_NUM_REQ = 4;
   localparam int ID_W        = $clog2(DEF_NUM_REQ);

   // Burst counter width; covers MAX_BURST up to 255
   localparam int BCNT_W      = 8;

   // Owner-id width for an arbitrary producer count (never narrower than 1)
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req searching cyclically from last_owner+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_owner,
   output logic          valid,
   output logic [IW-1:0] pick_id
);

   // Scan from the farthest candidate to the nearest so the nearest set bit
   // after last_owner is the one that sticks.
   always_comb begin
      int idx;
      valid   = 1'b0;
      pick_id = '0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last_owner) + k) % N;
         if (req[idx]) begin
            valid   = 1'b1;
            pick_id = IW'(idx);
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ producers. Never writes while the FIFO is full;
//               almost-full only blocks new grants.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int WIDTH     = 32,
   parameter  int MAX_BURST = 8,
   localparam int OWN_W     = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     sync_reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_wr_data,
   input  logic                     fifo_full,
   input  logic                     fifo_almost_full,
   output logic [OWN_W-1:0]         owner_id,
   output logic                     busy
);

   localparam logic [BCNT_W-1:0] LAST_CNT   = BCNT_W'(MAX_BURST - 1);
   localparam logic [OWN_W-1:0]  RESET_LAST = OWN_W'(NUM_REQ - 1);

   arb_state_t        state, state_nxt;
   logic [OWN_W-1:0]  owner, owner_nxt;
   logic [OWN_W-1:0]  last_owner, last_owner_nxt;
   logic [BCNT_W-1:0] burst_cnt, burst_cnt_nxt;

   logic              pick_valid;
   logic [OWN_W-1:0]  pick_id;
   logic              in_grant;
   logic              owner_req;
   logic              xfer;
   logic              burst_last;
   logic [OWN_W-1:0]  data_sel;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (OWN_W)
   ) u_rr_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .pick_id    (pick_id)
   );

   // State register; reset leaves last_owner at the top index so producer 0
   // is searched first.
   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= RESET_LAST;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         burst_cnt  <= burst_cnt_nxt;
      end
   end

   // Write strobe, grant and data mux; a full FIFO suppresses the write
   // because the FIFO would otherwise overwrite its contents.
   always_comb begin
      in_grant     = (state == GRANT);
      owner_req    = req[owner];
      xfer         = in_grant && owner_req && !fifo_full;
      burst_last   = (burst_cnt == LAST_CNT);
      data_sel     = in_grant ? owner : '0;
      gnt          = '0;
      gnt[owner]   = xfer;
      fifo_wr_en   = xfer;
      fifo_wr_data = req_data[int'(data_sel)*WIDTH +: WIDTH];
      owner_id     = owner;
      busy         = in_grant;
   end

   // Next-state: grant on any request with room, release on a dropped
   // request or a completed burst; full only stalls.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      burst_cnt_nxt  = burst_cnt;
      case (state)
         IDLE: begin
            if (pick_valid && !fifo_full && !fifo_almost_full) begin
               state_nxt     = GRANT;
               owner_nxt     = pick_id;
               burst_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               burst_cnt_nxt = burst_cnt + 1'b1;
               if (burst_last) begin
                  state_nxt      = IDLE;
                  last_owner_nxt = owner;
               end
            end else if (!owner_req) begin
               state_nxt      = IDLE;
               last_owner_nxt = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule : fifo_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed self-checking bench for fifo_write_arbiter, plus a
//               streaming run against a behavioural 32-deep FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 32;
   localparam int MAX_BURST = 8;

   logic                     clk = 1'b0;
   logic                     sync_reset;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       gnt;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_wr_data;
   logic                     fifo_full;
   logic                     fifo_almost_full;
   logic [1:0]               owner_id;
   logic                     busy;

   int checks = 0;
   int passes = 0;

   // {busy, owner_id, gnt, fifo_wr_en}
   logic [7:0] obs;
   logic [7:0] exp_v;

   fifo_write_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk              (clk),
      .sync_reset       (sync_reset),
      .req              (req),
      .req_data         (req_data),
      .gnt              (gnt),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .owner_id         (owner_id),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] data_of(input int i);
      return 32'hD000_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic load_data();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = data_of(i);
   endtask

   task automatic test_reset();
      sync_reset = 1'b1; req = '0; req_data = '0;
      fifo_full = 1'b0; fifo_almost_full = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({gnt, fifo_wr_en, busy, owner_id, fifo_wr_data} !== '0)
         $display("FAIL reset_outputs: got %h want 0", {gnt, fifo_wr_en, busy, owner_id, fifo_wr_data});
      else passes++;
      // requests during reset must not be granted
      req = 4'hF;
      @(negedge clk); #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'h00) $display("FAIL reset_hold: got %b want 00000000", obs);
      else passes++;
      req = '0; sync_reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_priority();
      logic [39:0] obs_d, exp_d;
      load_data();
      @(negedge clk); req = 4'hF; #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'h00) $display("FAIL prio_idle: got %b want 00000000", obs);
      else passes++;
      for (int o = 0; o < NUM_REQ; o++) begin
         for (int w = 0; w < MAX_BURST; w++) begin
            @(negedge clk); #1;
            obs_d = {busy, owner_id, gnt, fifo_wr_en, fifo_wr_data};
            exp_d = {1'b1, 2'(o), 4'(1 << o), 1'b1, data_of(o)};
            checks++;
            if (obs_d !== exp_d)
               $display("FAIL prio_burst o=%0d w=%0d: got %h want %h", o, w, obs_d, exp_d);
            else passes++;
         end
         @(negedge clk);
         if (o == NUM_REQ - 1) req = '0;
         #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         exp_v = {1'b0, 2'(o), 4'b0000, 1'b0};
         checks++;
         if (obs !== exp_v) $display("FAIL prio_bubble o=%0d: got %b want %b", o, obs, exp_v);
         else passes++;
      end
   endtask

   task automatic test_early_release();
      @(negedge clk); req = 4'b0100; #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs[7] !== 1'b0 || obs[4:0] !== 5'b0) $display("FAIL early_idle: got %b", obs);
      else passes++;
      repeat (3) begin
         @(negedge clk); #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         checks++;
         if (obs !== 8'b1_10_0100_1) $display("FAIL early_write: got %b want 11001001", obs);
         else passes++;
      end
      @(negedge clk); req = '0; #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'b1_10_0000_0) $display("FAIL early_release: got %b want 11000000", obs);
      else passes++;
      @(negedge clk); #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'b0_10_0000_0) $display("FAIL early_idle_after: got %b want 01000000", obs);
      else passes++;
   endtask

   // last_owner is 2 here, so req=1111 must go to owner 3
   task automatic test_full_stall();
      int n_wr = 0;
      @(negedge clk); req = 4'hF; #1;
      for (int c = 0; c < 3 + 5 + 5; c++) begin
         @(negedge clk);
         fifo_full = (c >= 3 && c < 8);
         #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         exp_v = fifo_full ? 8'b1_11_0000_0 : 8'b1_11_1000_1;
         if (fifo_wr_en) n_wr++;
         checks++;
         if (obs !== exp_v) $display("FAIL stall_cycle c=%0d: got %b want %b", c, obs, exp_v);
         else passes++;
      end
      fifo_full = 1'b0;
      @(negedge clk); req = '0; #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'b0_11_0000_0) $display("FAIL stall_end: got %b want 01100000", obs);
      else passes++;
      checks++;
      if (n_wr !== MAX_BURST) $display("FAIL stall_total: got %0d want %0d", n_wr, MAX_BURST);
      else passes++;
   endtask

   // last_owner is 3: first grant wraps to 0, the second skips 1 and lands on 2
   task automatic test_almost_full();
      for (int round = 0; round < 2; round++) begin
         @(negedge clk); fifo_almost_full = 1'b1; req = 4'b0101;
         for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            obs = {busy, owner_id, gnt, fifo_wr_en};
            checks++;
            if (obs[7] !== 1'b0 || obs[4:0] !== 5'b0) $display("FAIL af_block r=%0d c=%0d: got %b", round, c, obs);
            else passes++;
         end
         @(negedge clk); fifo_almost_full = 1'b0; #1;
         checks++;
         if (busy !== 1'b0) $display("FAIL af_drop r=%0d: busy got %b want 0", round, busy);
         else passes++;
         @(negedge clk); #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         exp_v = (round == 0) ? 8'b1_00_0001_1 : 8'b1_10_0100_1;
         checks++;
         if (obs !== exp_v) $display("FAIL af_grant r=%0d: got %b want %b", round, obs, exp_v);
         else passes++;
         if (round == 0) begin
            @(negedge clk); req = '0; #1;
            obs = {busy, owner_id, gnt, fifo_wr_en};
            checks++;
            if (obs !== 8'b1_00_0000_0) $display("FAIL af_release0: got %b want 10000000", obs);
            else passes++;
         end
      end
      // almost-full must not interrupt the burst in progress
      repeat (2) begin
         @(negedge clk); fifo_almost_full = 1'b1; #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         checks++;
         if (obs !== 8'b1_10_0100_1) $display("FAIL af_inburst: got %b want 11001001", obs);
         else passes++;
      end
      @(negedge clk); fifo_almost_full = 1'b0; req = '0; #1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0) $display("FAIL af_end: busy got %b want 0", busy);
      else passes++;
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk); req = 4'b1000; #1;
      for (int w = 0; w < 5; w++) begin
         @(negedge clk); #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         checks++;
         if (obs !== 8'b1_11_1000_1) $display("FAIL mid_pre w=%0d: got %b want 11110001", w, obs);
         else passes++;
      end
      #2 sync_reset = 1'b1;
      #1;
      obs = {busy, owner_id, gnt, fifo_wr_en};
      checks++;
      if (obs !== 8'h00) $display("FAIL mid_async: got %b want 00000000", obs);
      else passes++;
      @(negedge clk); sync_reset = 1'b0; #1;
      checks++;
      if (busy !== 1'b0) $display("FAIL mid_after_idle: busy got %b want 0", busy);
      else passes++;
      for (int c = 0; c < MAX_BURST + 2; c++) begin
         @(negedge clk); #1;
         obs = {busy, owner_id, gnt, fifo_wr_en};
         exp_v = (c == MAX_BURST) ? 8'b0_11_0000_0 : 8'b1_11_1000_1;
         checks++;
         if (obs !== exp_v) $display("FAIL mid_reburst c=%0d: got %b want %b", c, obs, exp_v);
         else passes++;
      end
      @(negedge clk); req = '0; #1;
      @(negedge clk); #1;
   endtask

   task automatic test_end_to_end();
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] w;
      int sent[NUM_REQ];
      int rcvd[NUM_REQ];
      int total = 0;
      int cyc = 0;
      int p;
      bit do_pop;
      for (int i = 0; i < NUM_REQ; i++) begin sent[i] = 0; rcvd[i] = 0; end
      while (total < 200 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (sent[i] < 50);
            req_data[i*WIDTH +: WIDTH] = {8'(i), 24'(sent[i])};
         end
         fifo_full        = (q.size() >= 32);
         fifo_almost_full = (q.size() >= 28);
         #1;
         do_pop = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         if (fifo_wr_en) begin
            p = int'(fifo_wr_data[31:24]);
            checks++;
            if (fifo_full) $display("FAIL e2e_write_when_full: wr_en got 1 want 0");
            else passes++;
            checks++;
            if (p >= NUM_REQ || gnt !== 4'(1 << p))
               $display("FAIL e2e_gnt_tag: gnt got %b tag %0d", gnt, p);
            else begin
               passes++;
               q.push_back(fifo_wr_data);
               sent[p]++;
            end
         end
         if (do_pop) begin
            w = q.pop_front();
            p = int'(w[31:24]);
            checks++;
            if (p >= NUM_REQ || int'(w[23:0]) !== rcvd[p])
               $display("FAIL e2e_order: got word %h want seq %0d", w, (p < NUM_REQ) ? rcvd[p] : -1);
            else passes++;
            if (p < NUM_REQ) rcvd[p]++;
            total++;
         end
      end
      req = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
      checks++;
      if (total !== 200) $display("FAIL e2e_timeout: got %0d words want 200", total);
      else passes++;
      for (int i = 0; i < NUM_REQ; i++) begin
         checks++;
         if (rcvd[i] !== 50) $display("FAIL e2e_count p=%0d: got %0d want 50", i, rcvd[i]);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_reset_priority();
      test_early_release();
      test_full_stall();
      test_almost_full();
      test_reset_mid_burst();
      test_end_to_end();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_fifo_write_arbiter
`default_nettype wire

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one `fifo` write port between `NUM_REQ` producers. Each grant is a burst of at most `MAX_BURST` words, and the arbiter never writes while the FIFO is full. It sits directly in front of the `fifo` instance and drives its `wr_en` and `wr_data`. It consumes the FIFO's `flag_full` and `flag_almost_full` as back-pressure.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers, 2..16.
- `WIDTH`, 32: data width; must equal the FIFO `width`.
- `MAX_BURST`, 8: maximum words per grant, 1..255.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `sync_reset`, in, 1: asynchronous, active-high reset.
- `req`, in, `NUM_REQ`: producer `i` has a word available on its data slice.
- `req_data`, in, `NUM_REQ*WIDTH`: producer `i` data is at bits `[i*WIDTH +: WIDTH]`.
- `gnt`, out, `NUM_REQ`: one-hot strobe; the producer's word is consumed this cycle.
- `fifo_wr_en`, out, 1: write strobe to the FIFO.
- `fifo_wr_data`, out, `WIDTH`: the owner's data slice.
- `fifo_full`, in, 1: FIFO full flag.
- `fifo_almost_full`, in, 1: FIFO almost-full flag.
- `owner_id`, out, `$clog2(NUM_REQ)`: current or last grant owner.
- `busy`, out, 1: high while in state `GRANT`.

## Operation
- The FSM has two states, `IDLE` and `GRANT`. Registered state is `state`, `owner`, `last_owner` and `burst_cnt` (8 bits).
- **IDLE → GRANT**:
  - Taken on the edge where `|req` is high, `!fifo_full` and `!fifo_almost_full`.
  - `owner` is set to the first requester searching cyclically from `last_owner+1`.
  - `burst_cnt` is cleared to 0.
- **In GRANT, a transfer occurs** when `req[owner] && !fifo_full`. In a transfer cycle:
  - `fifo_wr_en` is 1 and `gnt[owner]` is 1.
  - `fifo_wr_data` carries `req_data` slice `owner`.
  - `burst_cnt` is incremented at the edge.
- **In GRANT, with `fifo_full` high**: no transfer, stay in `GRANT`, `burst_cnt` holds. Full stalls a burst but never revokes it.
- **GRANT → IDLE**, with `last_owner <= owner`, on either of these edges:
  - `req[owner]` is low: a release cycle with no transfer.
  - A transfer cycle in which `burst_cnt == MAX_BURST-1`: the burst is complete.
- `fifo_almost_full` gates only new grants. An in-progress burst continues until `fifo_full`.
- Hard rule: `fifo_wr_en` is never 1 in the same cycle as `fifo_full`, because the FIFO stores data even when full.
- `gnt`, `fifo_wr_en` and `fifo_wr_data` are combinational from registered state, `req` and `fifo_full`. `fifo_wr_data` shows the owner slice whenever the state is `GRANT`.
- A producer that drops `req` mid-burst loses the grant. It is re-arbitrated normally, with lowest priority next round.

## Timing
- **Reset values**:
  - `state = IDLE`, `owner = 0`, `last_owner = NUM_REQ-1`, `burst_cnt = 0`. This gives `req[0]` first priority.
  - Outputs: `gnt = 0`, `fifo_wr_en = 0`, `busy = 0`, `owner_id = 0`.
  - `fifo_wr_data` is 0, since it shows slice 0 while in `IDLE`.
- **Arbitration latency**: `req` seen high at edge N enters `GRANT` at N. The first write is in cycle N→N+1, accepted by the FIFO at edge N+1.
- **Burst**: up to `MAX_BURST` consecutive `wr_en` cycles, followed by one `IDLE` bubble cycle before the next grant.
- **Throughput**: with all requesters streaming, `MAX_BURST` words per `MAX_BURST+1` cycles.
- **Reset mid-burst**: outputs drop immediately (asynchronous). After reset the next grant goes to `req[0]` first.
- **Single requester**: it is re-granted after each 1-cycle bubble.

## Structure
- **Package `fifo_arb_pkg`**:
  - State enum `arb_state_t` with values `IDLE` and `GRANT`.
  - Constant `ID_W = $clog2(NUM_REQ)`.
  - Burst counter width constant `BCNT_W = 8`.
- **Sub-module `rr_pick`**: combinational. Inputs are `req` and `last_owner`. Outputs are `valid` and `pick_id`, the first set bit cyclically after `last_owner`. It is reusable by the future read-side scheduler.
- **Top**: FSM, counters and output muxing only.

## Test plan
- **Reset priority**: after reset, `req = 4'b1111` with the FIFO empty → owner 0 is granted. Owner 0 gets 8 writes, then owners 1, 2, 3 in turn, each followed by a 1-cycle bubble.
- **Early release**: `req[2]` only, held for 3 cycles after the grant → exactly 3 writes with `gnt[2]`. Return to `IDLE`, `last_owner = 2`.
- **Full stall**: force `fifo_full` high during the 4th word of a burst for 5 cycles → `fifo_wr_en` is 0 for those 5 cycles and the owner is unchanged. Words 4–8 then complete and the burst totals 8 writes.
- **Almost-full gating**: `fifo_almost_full = 1` in `IDLE` with `req = 4'b0101` → no grant until it drops. The grant then goes to the next requester after `last_owner`.
- **Asynchronous reset mid-burst**: assert `sync_reset` during word 5 of owner 3's burst → `gnt` and `fifo_wr_en` go to 0 immediately. After release, `req = 4'b1000` is granted to owner 3 starting at `burst_cnt = 0`.
- **End-to-end**: connect to `fifo` (depth 32) and stream 200 tagged words from 4 producers → every word is read back exactly once. Per-producer order is preserved and no write occurs while `flag_full` is high.
